pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the microcontroller core: the next generation of the PC/return-address path. It replaces the single-entry return register with a return-address stack of configurable depth. It also generalises PC width and relative-branch offset width, and adds a fetch-enable hold and sticky stack-error reporting. It sits between the control unit (select strobes) and the program memory (drives `pc`).

---
 rtl/pcseq_pkg.sv | 7 +
 rtl/pc_sequencer_if.sv | 21 ++
 rtl/ras_stack.sv | 64 ++++++
 rtl/pc_sequencer.sv | 53 +++++
 tb/tb_pc_sequencer.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/pcseq_pkg.sv
// pcseq_pkg: shared defaults and next-PC source encoding for pc_sequencer
package pcseq_pkg;
  localparam int PCW_DEF = 10;
  localparam int OFFW_DEF = 9;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {SRC_INC, SRC_ABS, SRC_RET, SRC_REL} pc_src_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control strobes in, PC and return-stack status out
interface pc_sequencer_if import pcseq_pkg::*; #(
  parameter int PCW = PCW_DEF,
  parameter int OFFW = OFFW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int DW = $clog2(DEPTH + 1);
  logic en, s_inc, s_call, s_ret, s_rel, rel_sign, err_clr;
  logic [PCW-1:0] abs_addr, pc;
  logic [OFFW-1:0] rel_mag;
  logic [DW-1:0] ras_depth;
  logic ras_empty, ras_full, ras_err;
  modport master(
    output en, s_inc, abs_addr, s_call, s_ret, s_rel, rel_sign, rel_mag, err_clr,
    input pc, ras_depth, ras_empty, ras_full, ras_err
  );
  modport slave(
    input en, s_inc, abs_addr, s_call, s_ret, s_rel, rel_sign, rel_mag, err_clr,
    output pc, ras_depth, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: return-address LIFO with push/pop/replace and overflow/underflow pulses
// PCSEQ_RAS_CIRC_EN makes push-on-full overwrite the oldest entry instead of dropping.
module ras_stack #(
  parameter int W = 10,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_top,
  output logic [DW-1:0] o_depth,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf
);
`ifdef PCSEQ_RAS_CIRC_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [DW-1:0] r_depth;
  logic [AW-1:0] w_top, w_wp_inc;
  logic w_repl, w_psh, w_pop;
  // r_wp is the next write slot; the ring lets circular mode reuse the oldest slot
  always_comb begin
    w_top = r_wp == '0 ? AW'(DEPTH - 1) : r_wp - AW'(1);
    w_wp_inc = r_wp == AW'(DEPTH - 1) ? '0 : r_wp + AW'(1);
    o_depth = r_depth;
    o_empty = r_depth == '0;
    o_full = r_depth == DW'(DEPTH);
    w_repl = i_push & i_pop & !o_empty;
    w_psh = i_push & (!i_pop | o_empty) & (!o_full | CIRC);
    w_pop = i_pop & !i_push & !o_empty;
    o_ovf = i_push & !i_pop & o_full & !CIRC;
    o_unf = i_pop & !i_push & o_empty;
    o_top = r_mem[w_top];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_depth <= '0;
    end else if (i_en) begin
      if (w_psh) begin
        r_wp <= w_wp_inc;
        r_depth <= o_full ? r_depth : r_depth + DW'(1);
      end else if (w_pop) begin
        r_wp <= w_top;
        r_depth <= r_depth - DW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (i_en & w_repl) r_mem[w_top] <= i_data;
    else if (i_en & w_psh) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, branch adders, source select and sticky stack error
// Stack overflow policy selectable with PCSEQ_RAS_CIRC_EN (see ras_stack).
module pc_sequencer import pcseq_pkg::*; #(
  parameter int PCW = PCW_DEF,
  parameter int OFFW = OFFW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  pc_sequencer_if.slave bus
);
  logic [PCW-1:0] r_pc, w_inc, w_rel, w_top, w_next, w_mag;
  logic r_err, w_ovf, w_unf, w_empty;
  pc_src_e w_src;
  ras_stack #(.W(PCW), .DEPTH(DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .i_en(bus.en),
    .i_push(bus.s_call),
    .i_pop(bus.s_ret),
    .i_data(w_inc),
    .o_top(w_top),
    .o_depth(bus.ras_depth),
    .o_empty(w_empty),
    .o_full(bus.ras_full),
    .o_ovf(w_ovf),
    .o_unf(w_unf)
  );
  // underflowing return falls through to pc+1; call+ret on empty acts as a plain call
  always_comb begin
    w_inc = r_pc + PCW'(1);
    w_mag = {{(PCW-OFFW){1'b0}}, bus.rel_mag};
    w_rel = bus.rel_sign ? r_pc - w_mag : r_pc + w_mag;
    w_src = bus.s_rel ? SRC_REL
          : bus.s_ret & !w_empty ? SRC_RET
          : w_unf | bus.s_inc ? SRC_INC : SRC_ABS;
    w_next = w_src == SRC_REL ? w_rel
           : w_src == SRC_RET ? w_top
           : w_src == SRC_INC ? w_inc : bus.abs_addr;
    bus.pc = r_pc;
    bus.ras_empty = w_empty;
    bus.ras_err = r_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
      r_err <= 1'b0;
    end else if (bus.en) begin
      r_pc <= w_next;
      r_err <= (w_ovf | w_unf) ? 1'b1 : bus.err_clr ? 1'b0 : r_err;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table, corner sequences and random run against a queue model
module tb_pc_sequencer;
`ifdef PCSEQ_RAS_CIRC_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  localparam int D = 4;
  logic clk = 0;
  logic reset;
  int n_chk = 0, n_err = 0;
  int m_pc;
  int m_q[$];
  bit m_err;
  pc_sequencer_if #(.PCW(10), .OFFW(9), .DEPTH(D)) bus();
  pc_sequencer #(.PCW(10), .OFFW(9), .DEPTH(D)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit en, inc; int abs; bit call, ret, rel, sign; int mag; bit clr; int epc, edep;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int inc, nxt;
    bit e;
    if (reset) begin
      m_pc = 0; m_q.delete(); m_err = 0;
      return;
    end
    if (!bus.en) return;
    inc = (m_pc + 1) & 1023;
    nxt = bus.s_inc ? inc : int'(bus.abs_addr);
    e = 0;
    if (bus.s_call && bus.s_ret) begin
      if (m_q.size() > 0) begin
        nxt = m_q[m_q.size()-1];
        m_q[m_q.size()-1] = inc;
      end else m_q.push_back(inc);
    end else if (bus.s_ret) begin
      if (m_q.size() > 0) nxt = m_q.pop_back();
      else begin nxt = inc; e = 1; end
    end else if (bus.s_call) begin
      if (m_q.size() < D) m_q.push_back(inc);
      else if (CIRC) begin void'(m_q.pop_front()); m_q.push_back(inc); end
      else e = 1;
    end
    if (bus.s_rel) nxt = (bus.rel_sign ? m_pc - int'(bus.rel_mag) : m_pc + int'(bus.rel_mag)) & 1023;
    m_pc = nxt;
    m_err = e ? 1'b1 : bus.err_clr ? 1'b0 : m_err;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", int'(bus.pc), m_pc);
    chk("depth", int'(bus.ras_depth), m_q.size());
    chk("empty", int'(bus.ras_empty), int'(m_q.size() == 0));
    chk("full", int'(bus.ras_full), int'(m_q.size() == D));
    chk("err", int'(bus.ras_err), int'(m_err));
  endtask

  task automatic apply(input bit en, inc, input int abs, input bit call, ret, rel, sign,
                       input int mag, input bit clr);
    bus.en = en; bus.s_inc = inc; bus.abs_addr = 10'(abs); bus.s_call = call;
    bus.s_ret = ret; bus.s_rel = rel; bus.rel_sign = sign; bus.rel_mag = 9'(mag); bus.err_clr = clr;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1;
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
  endtask

  initial begin
    int exp_ret[4];
    tbl[0]  = '{1,1,0,0,0,0,0,0,0, 1, 0};
    tbl[1]  = '{1,1,0,0,0,0,0,0,0, 2, 0};
    tbl[2]  = '{1,1,0,0,0,0,0,0,0, 3, 0};
    tbl[3]  = '{1,1,0,0,0,0,0,0,0, 4, 0};
    tbl[4]  = '{1,1,0,0,0,0,0,0,0, 5, 0};
    tbl[5]  = '{1,0,'h100,1,0,0,0,0,0, 'h100, 1};
    tbl[6]  = '{1,0,'h200,1,0,0,0,0,0, 'h200, 2};
    tbl[7]  = '{1,0,0,0,1,0,0,0,0, 'h101, 1};
    tbl[8]  = '{1,0,0,0,1,0,0,0,0, 6, 0};
    tbl[9]  = '{1,0,3,0,0,0,0,0,0, 3, 0};
    tbl[10] = '{1,0,0,0,0,1,1,5,0, 'h3FE, 0};
    tbl[11] = '{1,1,0,0,0,0,0,0,0, 'h3FF, 0};
    tbl[12] = '{1,1,0,0,0,0,0,0,0, 0, 0};
    tbl[13] = '{1,0,'h3F,0,0,0,0,0,0, 'h3F, 0};
    tbl[14] = '{1,0,'h80,1,0,0,0,0,0, 'h80, 1};
    tbl[15] = '{1,0,0,1,1,0,0,0,0, 'h40, 1};
    tbl[16] = '{1,0,0,0,1,0,0,0,0, 'h81, 0};
    tbl[17] = '{1,1,0,0,0,1,0,0,0, 'h81, 0};
    reset = 1;
    bus.en = 0; bus.s_inc = 0; bus.abs_addr = 0; bus.s_call = 0; bus.s_ret = 0;
    bus.s_rel = 0; bus.rel_sign = 0; bus.rel_mag = 0; bus.err_clr = 0;
    do_reset();
    chk("reset_pc", int'(bus.pc), 0);
    chk("reset_empty", int'(bus.ras_empty), 1);
    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].inc, tbl[i].abs, tbl[i].call, tbl[i].ret, tbl[i].rel,
            tbl[i].sign, tbl[i].mag, tbl[i].clr);
      chk($sformatf("tbl%0d_pc", i), int'(bus.pc), tbl[i].epc);
      chk($sformatf("tbl%0d_depth", i), int'(bus.ras_depth), tbl[i].edep);
    end
    // five nested calls into a four-deep stack
    do_reset();
    for (int k = 1; k <= 5; k++) apply(1, 0, k * 16, 1, 0, 0, 0, 0, 0);
    chk("nest_err", int'(bus.ras_err), CIRC ? 0 : 1);
    chk("nest_depth", int'(bus.ras_depth), 4);
    exp_ret = CIRC ? '{'h41, 'h31, 'h21, 'h11} : '{'h31, 'h21, 'h11, 'h01};
    for (int k = 0; k < 4; k++) begin
      apply(1, 0, 0, 0, 1, 0, 0, 0, 0);
      chk($sformatf("nest_ret%0d", k), int'(bus.pc), exp_ret[k]);
    end
    apply(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("underflow_pc", int'(bus.pc), exp_ret[3] + 1);
    chk("underflow_err", int'(bus.ras_err), 1);
    for (int k = 0; k < 3; k++) apply(0, 1, 'h155, 1, 1, 1, 1, 7, 1);
    chk("hold_pc", int'(bus.pc), exp_ret[3] + 1);
    chk("hold_err", int'(bus.ras_err), 1);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_err", int'(bus.ras_err), 0);
    apply(1, 0, 0, 0, 1, 0, 0, 0, 1);
    chk("clr_vs_err", int'(bus.ras_err), 1);
    apply(1, 0, 'h300, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 'h310, 1, 0, 0, 0, 0, 0);
    reset = 1;
    apply(1, 0, 'h320, 1, 0, 0, 0, 0, 0);
    reset = 0;
    chk("midreset_pc", int'(bus.pc), 0);
    chk("midreset_depth", int'(bus.ras_depth), 0);
    for (int n = 0; n < 600; n++) begin
      reset = $urandom_range(0, 99) < 2;
      apply($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 1023),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            1'($urandom), $urandom_range(0, 511), $urandom_range(0, 9) == 0);
    end
    reset = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
